mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameter WIDTH SHALL default to 32 and set the operand and HI/LO width.
REQ-003 Parameter ITER SHALL default to 32 and set the number of shift/add or shift/subtract iterations.
REQ-004 clk SHALL be a 1-bit input: rising-edge clock.
REQ-005 reset SHALL be a 1-bit input: asynchronous, active-high reset.
REQ-006 start SHALL be a 1-bit input: request a new operation; sampled only in IDLE.
REQ-007 mdOp SHALL be a 3-bit input with these codes: MULT 000, MULTU 001, DIV 010, DIVU 011, MTHI 100, MTLO 101; codes 110 and 111 are no-ops.
REQ-008 data1 SHALL be a 32-bit input: multiplicand or dividend, and the MTHI/MTLO source.
REQ-009 data2 SHALL be a 32-bit input: multiplier or divisor.
REQ-010 busy SHALL be a 1-bit output that is high while an operation is in progress.
REQ-011 done SHALL be a 1-bit output that pulses high for one cycle when HI/LO are updated by a MULT, MULTU, DIV or DIVU.
REQ-012 divByZero SHALL be a 1-bit output, asserted together with done when the divisor is zero.
REQ-013 hi SHALL be a 32-bit output showing the current HI register.
REQ-014 lo SHALL be a 32-bit output showing the current LO register.

Function
REQ-015 The state machine SHALL have the states IDLE, RUN, FIX and DONE.
REQ-016 In IDLE, start=1 with a MULT, MULTU, DIV or DIVU code SHALL latch the operands and op, clear the iteration counter, and go to RUN.
REQ-017 In IDLE, start=1 with MTHI or MTLO SHALL write data1 into HI or LO at that edge, stay in IDLE, and not assert done.
REQ-018 start with code 110 or 111, and start while not in IDLE, SHALL be ignored with no state change.
REQ-019 RUN SHALL perform exactly ITER iterations, one per cycle, then go to FIX.
REQ-020 FIX SHALL apply the sign correction, write HI/LO, and go to DONE; DONE SHALL return to IDLE on the next edge.
REQ-021 busy SHALL equal 1 in RUN and FIX; done SHALL equal 1 in DONE only.
REQ-022 Latency: with start sampled at edge 0, HI/LO SHALL update at edge 33 and done SHALL be high from edge 33 to edge 34; a new start SHALL be accepted at edge 34.
REQ-023 hi and lo SHALL hold their previous values throughout RUN and FIX.
REQ-024 MULT and MULTU SHALL form the full 64-bit product, placing bits 63:32 in HI and bits 31:0 in LO.
REQ-025 MULT SHALL treat operands as two's-complement; MULTU SHALL treat them as unsigned.
REQ-026 DIV and DIVU SHALL use restoring division, placing the quotient in LO and the remainder in HI.
REQ-027 For DIV, the quotient SHALL truncate toward zero and the remainder SHALL take the sign of the dividend.
REQ-028 Signed operations SHALL operate on magnitudes in RUN, with the sign applied in FIX.
REQ-029 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0, with no flag raised.
REQ-030 Division by zero SHALL keep the full latency, give HI=data1 and LO=0xFFFFFFFF, and assert divByZero only while done=1.

Reset
REQ-031 Asserting reset at any time, including mid-RUN or mid-FIX, SHALL immediately force IDLE and HI=LO=0.
REQ-032 Asserting reset SHALL immediately force busy=0, done=0, divByZero=0, and clear the counter and operand latches.
REQ-033 No partial result SHALL ever reach HI/LO after reset is released.

Structure
REQ-034 The shared package md_pkg SHALL hold the mdOp encodings, the state enumeration, and the WIDTH/ITER constants.
REQ-035 The single sub-module md_shift_core SHALL hold the 64-bit remainder/product shift register and the 33-bit add/subtract datapath, under a step enable and a mode select.
REQ-036 The control FSM, the sign fix-up logic and the HI/LO registers SHALL stay in mul_div_unit.

Verification
REQ-037 MULT with data1=0xFFFFFFFF and data2=0x00000002 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE, with done at edge 33.
REQ-038 MULTU with data1=0xFFFFFFFF and data2=0x00000002 -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-039 DIV with data1=0xFFFFFFF9 and data2=0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU with 100/7 -> LO=14, HI=2.
REQ-040 DIVU with data1=0x64 and data2=0 -> divByZero=1 in the done cycle, HI=0x64, LO=0xFFFFFFFF.
REQ-041 DIV with data1=0x80000000 and data2=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-042 MTLO with 0x1234 -> lo=0x1234 at the next edge with no done; start while busy -> ignored.
REQ-043 reset at edge 10 of a MULT -> busy=0 and hi=lo=0 immediately.

Source files
------------

// File: rtl/md_pkg.sv
// Shared encodings and constants for the multiply/divide unit.
package md_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_ITER  = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } md_state_e;

  function automatic logic op_is_arith(input logic [2:0] op);
    return ~op[2];
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return ~op[2] & ~op[0];
  endfunction

endpackage

// File: rtl/md_shift_core.sv
// Shared 2*WIDTH shift register with one WIDTH+1 bit adder: shift/add multiply
// (LSB first) or restoring divide (remainder in upper half, quotient in lower).
module md_shift_core
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic                 div_mode_i,
  input  logic [WIDTH-1:0]     load_val_i,
  input  logic [WIDTH-1:0]     opb_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     add_a, add_b, add_s;
  logic [WIDTH-1:0]   hi_w, lo_w;

  assign hi_w  = acc_q[2*WIDTH-1:WIDTH];
  assign lo_w  = acc_q[WIDTH-1:0];
  assign acc_o = acc_q;

  // Divide subtracts via inverted operand plus carry-in; add_s[WIDTH] is the borrow.
  always_comb begin
    add_a = div_mode_i ? {hi_w, lo_w[WIDTH-1]} : {1'b0, hi_w};
    add_b = div_mode_i ? ~{1'b0, opb_i} : {1'b0, opb_i};
    add_s = add_a + add_b + {{WIDTH{1'b0}}, div_mode_i};
    if (div_mode_i) begin
      acc_d = add_s[WIDTH] ? {add_a[WIDTH-1:0], lo_w[WIDTH-2:0], 1'b0}
                           : {add_s[WIDTH-1:0], lo_w[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = lo_w[0] ? {add_s, lo_w[WIDTH-1:1]}
                      : {1'b0, hi_w, lo_w[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else if (load_i) begin
      acc_q <= {{WIDTH{1'b0}}, load_val_i};
    end else if (step_i) begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
module mul_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITER  = MD_ITER
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mdOp,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(ITER + 1);

  md_state_e          state_q;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   d1_q, d2_q, hi_q, lo_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q, done_q, dbz_q;
  logic               issue_ok, core_load, core_step;
  logic               sgn_op, neg_a, neg_b, div_zero;
  logic [WIDTH-1:0]   load_mag, b_mag, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] acc, prod_fix;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_d(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  // DONE doubles as an issue slot so back-to-back operations keep a fixed cadence.
  assign issue_ok  = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign core_load = issue_ok && op_is_arith(mdOp);
  assign core_step = (state_q == ST_RUN);
  assign load_mag  = mag(data1, op_is_signed(mdOp));

  assign sgn_op    = op_is_signed(op_q);
  assign neg_a     = sgn_op & d1_q[WIDTH-1];
  assign neg_b     = sgn_op & d2_q[WIDTH-1];
  assign b_mag     = mag(d2_q, sgn_op);
  assign div_zero  = op_q[1] && (d2_q == '0);
  assign prod_fix  = neg_d(acc, neg_a ^ neg_b);
  assign quo_fix   = neg_w(acc[WIDTH-1:0], neg_a ^ neg_b);
  assign rem_fix   = neg_w(acc[2*WIDTH-1:WIDTH], neg_a);

  md_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .reset      (reset),
    .load_i     (core_load),
    .step_i     (core_step),
    .div_mode_i (op_q[1]),
    .load_val_i (load_mag),
    .opb_i      (b_mag),
    .acc_o      (acc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q  <= 1'b0;
          dbz_q   <= 1'b0;
          state_q <= ST_IDLE;
          if (issue_ok) begin
            if (op_is_arith(mdOp)) begin
              op_q    <= mdOp;
              d1_q    <= data1;
              d2_q    <= data2;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= ST_RUN;
            end else if (mdOp == OP_MTHI) begin
              hi_q <= data1;
            end else if (mdOp == OP_MTLO) begin
              lo_q <= data1;
            end
          end
        end
        ST_RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(ITER - 1)) state_q <= ST_FIX;
        end
        ST_FIX: begin
          if (!op_q[1]) begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end else if (div_zero) begin
            hi_q <= d1_q;
            lo_q <= '1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
          dbz_q   <= div_zero;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign divByZero = dbz_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized and directed checks of mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  mdOp;
  logic [31:0] data1, data2;
  logic        busy, done, divByZero;
  logic [31:0] hi, lo;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  mul_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mdOp      (mdOp),
    .data1     (data1),
    .data2     (data2),
    .busy      (busy),
    .done      (done),
    .divByZero (divByZero),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 64-bit arithmetic, SV division truncates toward zero.
  task automatic ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] eh, output logic [31:0] el,
                        output logic dz, output logic arith);
    longint      sa, sb, q, r;
    logic [63:0] p;
    eh = hi_m; el = lo_m; dz = 1'b0; arith = (op <= 3'd3);
    case (op)
      3'd0: begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
        p = sa * sb; eh = p[63:32]; el = p[31:0];
      end
      3'd1: begin
        p = {32'd0, a} * {32'd0, b}; eh = p[63:32]; el = p[31:0];
      end
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          eh = a; el = 32'hFFFF_FFFF; dz = 1'b1;
        end else if (op == 3'd2) begin
          sa = longint'($signed(a)); sb = longint'($signed(b));
          q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0];
        end else begin
          el = a / b; eh = a % b;
        end
      end
      3'd4: eh = a;
      3'd5: el = a;
      default: ;
    endcase
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit inject_busy);
    logic [31:0] eh, el;
    logic        dz, arith;
    int          n;
    ref_op(op, a, b, eh, el, dz, arith);
    start = 1'b1; mdOp = op; data1 = a; data2 = b;
    tick();
    start = 1'b0;
    if (!arith) begin
      check_val("mt_hi", hi, eh);
      check_val("mt_lo", lo, el);
      check_val("mt_done", done, 1'b0);
      check_val("mt_busy", busy, 1'b0);
      hi_m = eh; lo_m = el;
      return;
    end
    check_val("busy_start", busy, 1'b1);
    check_val("done_start", done, 1'b0);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (inject_busy && n == 5) begin
        start = 1'b1; mdOp = OP_MTLO; data1 = ~el;
      end else begin
        start = 1'b0;
      end
      if (n == 20) begin
        check_val("hold_hi", hi, hi_m);
        check_val("hold_lo", lo, lo_m);
        check_val("busy_run", busy, 1'b1);
      end
    end
    check_val("latency", n, 33);
    check_val("res_hi", hi, eh);
    check_val("res_lo", lo, el);
    check_val("dbz", divByZero, dz);
    check_val("busy_done", busy, 1'b0);
    hi_m = eh; lo_m = el;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; mdOp = '0; data1 = '0; data2 = '0;
    repeat (3) tick();
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_dbz", divByZero, 1'b0);
    check_val("rst_hi", hi, 32'd0);
    check_val("rst_lo", lo, 32'd0);
    reset = 1'b0;
    tick();

    do_op(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    check_val("mult_hi", hi, 32'hFFFF_FFFF);
    check_val("mult_lo", lo, 32'hFFFF_FFFE);
    tick();
    check_val("done_drop", done, 1'b0);

    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    check_val("multu_hi", hi, 32'h0000_0001);
    check_val("multu_lo", lo, 32'hFFFF_FFFE);

    // issued in the done cycle: back-to-back acceptance
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    check_val("div_lo", lo, 32'hFFFF_FFFD);
    check_val("div_hi", hi, 32'hFFFF_FFFF);

    do_op(OP_DIVU, 32'd100, 32'd7, 1'b1);
    check_val("divu_lo", lo, 32'd14);
    check_val("divu_hi", hi, 32'd2);

    do_op(OP_DIVU, 32'h64, 32'd0, 1'b0);
    check_val("dz_flag", divByZero, 1'b1);
    check_val("dz_hi", hi, 32'h64);
    check_val("dz_lo", lo, 32'hFFFF_FFFF);
    tick();
    check_val("dz_clear", divByZero, 1'b0);

    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check_val("ovf_lo", lo, 32'h8000_0000);
    check_val("ovf_hi", hi, 32'h0);
    check_val("ovf_flag", divByZero, 1'b0);

    do_op(OP_MTLO, 32'h1234, 32'h0, 1'b0);
    check_val("mtlo_lo", lo, 32'h1234);
    do_op(3'b110, 32'hDEAD_BEEF, 32'h5, 1'b0);
    do_op(3'b111, 32'hCAFE_F00D, 32'h5, 1'b0);

    for (int i = 0; i < 60; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
      do_op(3'($urandom_range(0, 7)), pick(), pick(), bit'($urandom_range(0, 1)));
    end

    do_op(OP_MTHI, 32'hAAAA_5555, 32'h0, 1'b0);
    do_op(OP_MTLO, 32'h5555_AAAA, 32'h0, 1'b0);
    start = 1'b1; mdOp = OP_MULT; data1 = 32'h1234_5678; data2 = 32'h9ABC_DEF0;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check_val("pre_rst_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check_val("mid_rst_busy", busy, 1'b0);
    check_val("mid_rst_done", done, 1'b0);
    check_val("mid_rst_hi", hi, 32'd0);
    check_val("mid_rst_lo", lo, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    hi_m = '0; lo_m = '0;
    repeat (40) tick();
    check_val("post_rst_hi", hi, 32'd0);
    check_val("post_rst_lo", lo, 32'd0);
    check_val("post_rst_done", done, 1'b0);
    check_val("post_rst_busy", busy, 1'b0);

    do_op(OP_MULT, 32'hFFFF_FFF9, 32'h0000_0003, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
